pc_fetch_unit: RTL and testbench

- Parametrised next-generation program counter for the fetch stage.
- Owns the PC register and selects the next PC: sequential, register-indirect, absolute jump, PC-relative branch, or exception vector.
- Drives the instruction-memory request with a ready handshake, and supports stall, halt and exception capture (EPC).
- Sits between the control/decode redirect logic and the instruction memory port.

---
 rtl/pc_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter and next-PC selection.
// Owns the PC and the EPC, drives the instruction-memory request, and
// handles stall, halt and exception redirect.
// Optional return-address stack: define PC_RAS_EN to build it. Without it
// link/ret are ignored and ras_mispredict is tied low.
module pc_fetch_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] PC_INIT    = '0,
    parameter logic [31:0]     EXC_VECTOR = 32'h0000_0080,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [1:0]      pc_sel,
    input  logic [PC_W-1:0] jr_a,
    input  logic [25:0]     jump_a,
    input  logic [PC_W-1:0] ext32,
    input  logic            link,
    input  logic            ret,
    input  logic            stall,
    input  logic            halt,
    input  logic            exc_req,
    input  logic            ihit,
    output logic            iren,
    output logic [PC_W-1:0] iaddr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] epc,
    output logic            halted,
    output logic            ras_mispredict
);

    localparam logic [1:0] SEL_NPC    = 2'd0;
    localparam logic [1:0] SEL_JR     = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_BRANCH = 2'd3;

    localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VECTOR);

    // S_WAKE is the fetch state for the first cycle out of reset, before
    // the request is raised; it honours halt/exception but never ihit.
    typedef enum logic [1:0] {
        S_WAKE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [PC_W-1:0] npc, next_pc;
    logic            active, do_exc, commit;

    // Redirect qualifiers in priority order: halt > exception > stall > ihit.
    assign active = (state_q != S_HALTED);
    assign do_exc = active & ~halt & exc_req;
    assign commit = (state_q == S_FETCH) & ~halt & ~exc_req & ~stall & ihit;

    // Candidate next PC for the currently selected redirect source.
    always_comb begin
        npc     = pc_q + PC_W'(4);
        next_pc = npc;
        case (pc_sel)
            SEL_NPC:    next_pc = npc;
            SEL_JR:     next_pc = jr_a;
            SEL_JUMP:   next_pc = {npc[PC_W-1:28], jump_a, 2'b00};
            SEL_BRANCH: next_pc = npc + (ext32 << 2);
            default:    next_pc = npc;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= S_WAKE;
        else       state_q <= state_d;
    end

    // Next-state: halt is sticky until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAKE, S_FETCH: state_d = halt ? S_HALTED : S_FETCH;
            S_HALTED:        state_d = S_HALTED;
            default:         state_d = S_WAKE;
        endcase
    end

    // Outputs decoded from state; fetch address always mirrors the PC.
    always_comb begin
        iren   = (state_q == S_FETCH);
        halted = (state_q == S_HALTED);
        pc     = pc_q;
        epc    = epc_q;
        iaddr  = pc_q;
    end

    // PC / EPC next-state: exception wins over a committed fetch.
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (do_exc) begin
            pc_d  = EXC_PC;
            epc_d = pc_q;
        end else if (commit) begin
            pc_d = next_pc;
        end
    end

    // PC and EPC registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q  <= PC_INIT;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = SP_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic [PC_W-1:0]  ras_top;
    logic             do_push, do_pop;

    // sp points at the next free slot; the top lives one below it.
    assign ras_top = ras_q[sp_q - SP_W'(1)];
    assign do_push = commit & (pc_sel == SEL_JUMP) & link;
    assign do_pop  = commit & (pc_sel == SEL_JR) & ret & (cnt_q != '0);

    // Stack pointer / occupancy next-state; a full push overwrites the oldest.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        mis_d = do_pop & (ras_top != jr_a);
        if (do_exc) begin
            sp_d  = '0;
            cnt_d = '0;
        end else if (do_push) begin
            sp_d  = sp_q + SP_W'(1);
            cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            sp_d  = sp_q - SP_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Return-address storage, pointers and the mispredict pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sp_q  <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
            if (do_push && !do_exc) ras_q[sp_q] <= npc;
        end
    end

    assign ras_mispredict = mis_q;
`else
    // No return-address stack in this build.
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_in;
    assign unused_ras_in  = link ^ ret;
    assign ras_mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a random
// run compared against a behavioural model (RAS modelled as a queue).
module tb_pc_fetch_unit;

    logic        CLK, nRST;
    logic [1:0]  pc_sel;
    logic [31:0] jr_a, ext32;
    logic [25:0] jump_a;
    logic        link, ret, stall, halt, exc_req, ihit;
    logic        iren, halted, ras_mispredict;
    logic [31:0] iaddr, pc, epc;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(
        .PC_W(32), .PC_INIT(32'h100), .EXC_VECTOR(32'h80), .RAS_DEPTH(2)
    ) dut (
        .CLK(CLK), .nRST(nRST), .pc_sel(pc_sel), .jr_a(jr_a), .jump_a(jump_a),
        .ext32(ext32), .link(link), .ret(ret), .stall(stall), .halt(halt),
        .exc_req(exc_req), .ihit(ihit), .iren(iren), .iaddr(iaddr), .pc(pc),
        .epc(epc), .halted(halted), .ras_mispredict(ras_mispredict)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural model
    logic [31:0] m_pc, m_epc;
    bit          m_wake, m_halted, m_mis;
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        m_pc = 32'h100; m_epc = 32'h0; m_wake = 1; m_halted = 0; m_mis = 0;
        m_ras.delete();
    endfunction

    function automatic void model_step();
        logic [31:0] npc, tgt;
        m_mis = 0;
        if (m_halted) begin
        end else if (halt) begin
            m_halted = 1;
        end else if (exc_req) begin
            m_epc = m_pc; m_pc = 32'h80; m_ras.delete();
        end else if (!stall && !m_wake && ihit) begin
            npc = m_pc + 32'd4;
            case (pc_sel)
                2'd0: tgt = npc;
                2'd1: tgt = jr_a;
                2'd2: tgt = (npc & 32'hF000_0000) | ({6'b0, jump_a} * 32'd4);
                default: tgt = npc + ext32 * 32'd4;
            endcase
`ifdef PC_RAS_EN
            if (pc_sel == 2'd2 && link) begin
                m_ras.push_back(npc);
                if (m_ras.size() > 2) void'(m_ras.pop_front());
            end
            if (pc_sel == 2'd1 && ret && m_ras.size() > 0)
                m_mis = (m_ras.pop_back() != jr_a);
`endif
            m_pc = tgt;
        end
        m_wake = 0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] ja,
                         input logic [25:0] jmp, input logic lk, input logic rt);
        pc_sel = sel; jr_a = ja; jump_a = jmp; link = lk; ret = rt;
        ihit = 1; stall = 0; halt = 0; exc_req = 0; ext32 = 0;
        tick();
    endtask

    task automatic do_reset();
        nRST = 0;
        #2;
        nRST = 1;
        model_reset();
    endtask

    task automatic test_reset();
        nRST = 1; pc_sel = 0; jr_a = 0; jump_a = 0; ext32 = 0;
        link = 0; ret = 0; stall = 0; halt = 0; exc_req = 0; ihit = 0;
        #2 nRST = 0;
        #10;
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); end
        checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
        checks++; if (iren !== 1'b0 || halted !== 1'b0 || ras_mispredict !== 1'b0) begin
            failures++; $display("FAIL reset_flags iren=%b halted=%b mis=%b exp=0,0,0", iren, halted, ras_mispredict); end
        @(posedge CLK); #1;
        nRST = 1; model_reset();
        pc_sel = 0; ihit = 1;
        #2;
        checks++; if (iren !== 1'b0) begin failures++; $display("FAIL wake_iren got=%b exp=0", iren); end
        tick();
        checks++; if (pc !== 32'h100 || iren !== 1'b1) begin
            failures++; $display("FAIL seq0 pc=%h iren=%b exp=100,1", pc, iren); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'h100 + 32'(4 * i)) begin
                failures++; $display("FAIL seq%0d got=%h exp=%h", i, pc, 32'h100 + 32'(4 * i)); end
        end
    endtask

    task automatic test_branch_stall();
        drive(2'd1, 32'h200, 0, 0, 0);
        pc_sel = 2'd3; ext32 = 32'hFFFF_FFFE; tick();
        checks++; if (pc !== 32'h1FC) begin failures++; $display("FAIL branch_neg got=%h exp=1fc", pc); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h1FC) begin failures++; $display("FAIL stall_hold got=%h exp=1fc", pc); end
        end
        drive(2'd1, 32'h200, 0, 0, 0);
        pc_sel = 2'd3; ext32 = 32'd3; tick();
        checks++; if (pc !== 32'h210) begin failures++; $display("FAIL branch_pos got=%h exp=210", pc); end
    endtask

    task automatic test_jump_wait();
        drive(2'd1, 32'hA000_0000, 0, 0, 0);
        drive(2'd2, 0, 26'h10, 0, 0);
        checks++; if (pc !== 32'hA000_0040) begin failures++; $display("FAIL jump got=%h exp=a0000040", pc); end
        ihit = 0; pc_sel = 2'd1; jr_a = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'hA000_0040 || iaddr !== 32'hA000_0040 || iren !== 1'b1) begin
                failures++; $display("FAIL imem_wait pc=%h iaddr=%h iren=%b exp=a0000040,a0000040,1", pc, iaddr, iren); end
        end
        drive(2'd1, 32'h1234, 0, 0, 0);
        checks++; if (pc !== 32'h1234) begin failures++; $display("FAIL jr got=%h exp=1234", pc); end
    endtask

    task automatic test_ras();
`ifdef PC_RAS_EN
        for (int rep = 0; rep < 2; rep++) begin
            drive(2'd1, 32'h10, 0, 0, 0);
            drive(2'd2, 0, 26'h8, 1, 0);
            drive(2'd2, 0, 26'hC, 1, 0);
            drive(2'd2, 0, 26'h10, 1, 0);
            checks++; if (pc !== 32'h40) begin failures++; $display("FAIL ras_calls got=%h exp=40", pc); end
            if (rep == 0) begin
                drive(2'd1, 32'h34, 0, 0, 1);
                checks++; if (ras_mispredict !== 1'b0 || pc !== 32'h34) begin
                    failures++; $display("FAIL ras_ret1 mis=%b pc=%h exp=0,34", ras_mispredict, pc); end
                drive(2'd1, 32'h24, 0, 0, 1);
                checks++; if (ras_mispredict !== 1'b0 || pc !== 32'h24) begin
                    failures++; $display("FAIL ras_ret2 mis=%b pc=%h exp=0,24", ras_mispredict, pc); end
                drive(2'd1, 32'h14, 0, 0, 1);
                checks++; if (ras_mispredict !== 1'b0 || pc !== 32'h14) begin
                    failures++; $display("FAIL ras_empty mis=%b pc=%h exp=0,14", ras_mispredict, pc); end
            end else begin
                drive(2'd1, 32'h99, 0, 0, 1);
                checks++; if (ras_mispredict !== 1'b1 || pc !== 32'h99) begin
                    failures++; $display("FAIL ras_mispredict mis=%b pc=%h exp=1,99", ras_mispredict, pc); end
                drive(2'd0, 0, 0, 0, 0);
                checks++; if (ras_mispredict !== 1'b0) begin
                    failures++; $display("FAIL ras_pulse_len got=%b exp=0", ras_mispredict); end
            end
        end
`else
        drive(2'd2, 0, 26'h8, 1, 0);
        drive(2'd1, 32'h99, 0, 0, 1);
        checks++; if (ras_mispredict !== 1'b0 || pc !== 32'h99) begin
            failures++; $display("FAIL noras_ret mis=%b pc=%h exp=0,99", ras_mispredict, pc); end
`endif
    endtask

    task automatic test_exc_halt();
        drive(2'd1, 32'h300, 0, 0, 0);
        exc_req = 1; stall = 1; ihit = 0; tick();
        checks++; if (epc !== 32'h300 || pc !== 32'h80) begin
            failures++; $display("FAIL exception epc=%h pc=%h exp=300,80", epc, pc); end
        halt = 1; exc_req = 1; stall = 0; ihit = 1; tick();
        checks++; if (halted !== 1'b1 || epc !== 32'h300 || iren !== 1'b0 || pc !== 32'h80) begin
            failures++; $display("FAIL halt_prio halted=%b epc=%h iren=%b pc=%h exp=1,300,0,80", halted, epc, iren, pc); end
        halt = 0; exc_req = 0; pc_sel = 2'd1; jr_a = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h80 || halted !== 1'b1 || iren !== 1'b0) begin
                failures++; $display("FAIL halt_frozen pc=%h halted=%b iren=%b exp=80,1,0", pc, halted, iren); end
        end
        do_reset();
    endtask

    task automatic test_random();
        int hcnt = 0;
        for (int i = 0; i < 400; i++) begin
            pc_sel  = 2'($urandom);
            jr_a    = $urandom & 32'hFFFF_FFFC;
            jump_a  = 26'($urandom);
            ext32   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)));
            link    = 1'($urandom);
            ret     = 1'($urandom);
            stall   = ($urandom_range(0, 3) == 0);
            ihit    = ($urandom_range(0, 3) != 0);
            exc_req = ($urandom_range(0, 15) == 0);
            halt    = ($urandom_range(0, 79) == 0);
            if (ret && m_ras.size() > 0 && $urandom_range(0, 1) == 1) jr_a = m_ras[m_ras.size() - 1];
            tick();
            checks++; if (pc !== m_pc || iaddr !== m_pc) begin
                failures++; $display("FAIL rnd_pc cyc=%0d pc=%h iaddr=%h exp=%h", i, pc, iaddr, m_pc); end
            checks++; if (epc !== m_epc) begin
                failures++; $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", i, epc, m_epc); end
            checks++; if (iren !== (!m_wake && !m_halted) || halted !== m_halted) begin
                failures++; $display("FAIL rnd_state cyc=%0d iren=%b halted=%b exp=%b,%b", i, iren, halted, !m_wake && !m_halted, m_halted); end
            checks++; if (ras_mispredict !== m_mis) begin
                failures++; $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", i, ras_mispredict, m_mis); end
            hcnt = m_halted ? hcnt + 1 : 0;
            if (hcnt > 3) begin do_reset(); hcnt = 0; end
        end
    endtask

    task automatic test_reset_mid();
        drive(2'd1, 32'h40, 0, 0, 0);
        pc_sel = 0; ihit = 0; tick();
        checks++; if (pc !== 32'h40 || iren !== 1'b1) begin
            failures++; $display("FAIL mid_pre pc=%h iren=%b exp=40,1", pc, iren); end
        #3 nRST = 0;
        #1;
        checks++; if (pc !== 32'h100 || iren !== 1'b0 || halted !== 1'b0 || ras_mispredict !== 1'b0 || epc !== 32'h0) begin
            failures++; $display("FAIL mid_reset pc=%h iren=%b halted=%b mis=%b epc=%h exp=100,0,0,0,0", pc, iren, halted, ras_mispredict, epc); end
        @(posedge CLK); #1;
        nRST = 1; model_reset();
        pc_sel = 0; ihit = 1; tick();
        drive(2'd1, 32'h55, 0, 0, 1);
        checks++; if (ras_mispredict !== 1'b0 || pc !== 32'h55) begin
            failures++; $display("FAIL mid_ras_empty mis=%b pc=%h exp=0,55", ras_mispredict, pc); end
    endtask

    initial begin
        test_reset();
        test_branch_stall();
        test_jump_wait();
        test_ras();
        test_exc_halt();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
